// File: rtl/led_blink_pkg.sv
// Shared constants, activity FSM encoding and tap saturation helper for the LED blinker.
package led_blink_pkg;

  localparam logic [1:0] LED_OFF   = 2'd0;
  localparam logic [1:0] LED_ON    = 2'd1;
  localparam logic [1:0] LED_BLINK = 2'd2;
  localparam logic [1:0] LED_ACT   = 2'd3;

  typedef enum logic [1:0] {
    ACT_IDLE  = 2'd0,
    ACT_FLASH = 2'd1,
    ACT_GAP   = 2'd2
  } act_state_e;

  // Out-of-range taps clamp to the prescaler MSB instead of wrapping.
  function automatic int unsigned sat_tap(int unsigned tap, int unsigned cnt_w);
    return (tap >= cnt_w) ? cnt_w - 1 : tap;
  endfunction

endpackage

// File: rtl/led_act_fsm.sv
// Per-channel activity stretcher: lone event -> STRETCH lit cycles, traffic -> square wave.
module led_act_fsm
  import led_blink_pkg::*;
#(
  parameter int unsigned STRETCH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic evt,
  output logic led
);

  localparam int unsigned TimerW = $clog2(STRETCH);
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(STRETCH - 1);

  act_state_e        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              pending_q, pending_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ACT_IDLE;
      timer_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pending_d = pending_q;
    if (!enable) begin
      state_d   = ACT_IDLE;
      timer_d   = '0;
      pending_d = 1'b0;
    end else begin
      unique case (state_q)
        ACT_IDLE: begin
          if (evt) begin
            state_d = ACT_FLASH;
            timer_d = TimerLoad;
          end
        end
        ACT_FLASH: begin
          if (evt) pending_d = 1'b1;
          if (timer_q == '0) begin
            state_d = ACT_GAP;
            timer_d = TimerLoad;
          end else begin
            timer_d = timer_q - TimerW'(1);
          end
        end
        ACT_GAP: begin
          if (timer_q == '0) begin
            // An event landing on the decision cycle counts as pending.
            if (pending_q || evt) begin
              state_d   = ACT_FLASH;
              timer_d   = TimerLoad;
              pending_d = 1'b0;
            end else begin
              state_d = ACT_IDLE;
            end
          end else begin
            timer_d = timer_q - TimerW'(1);
            if (evt) pending_d = 1'b1;
          end
        end
        default: begin
          state_d   = ACT_IDLE;
          timer_d   = '0;
          pending_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    led = (state_q == ACT_FLASH);
  end

endmodule

// File: rtl/led_activity_blinker.sv
// Multi-channel LED driver: shared prescaler, per-channel OFF/ON/BLINK/ACTIVITY with registered out.
module led_activity_blinker
  import led_blink_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned STRETCH = 4194304,
  parameter int unsigned TAP_W   = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2*NUM_CH-1:0]       ch_mode,
  input  logic [TAP_W*NUM_CH-1:0]   ch_tap,
  input  logic [NUM_CH-1:0]         ch_event,
  output logic [NUM_CH-1:0]         led_out,
  output logic                      presc_wrap
);

  logic [CNT_W-1:0]  cnt_q;
  logic [NUM_CH-1:0] led_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      presc_wrap <= 1'b0;
      led_out    <= '0;
    end else begin
      cnt_q      <= cnt_q + CNT_W'(1);
      presc_wrap <= &cnt_q;
      led_out    <= led_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       mode;
    logic [TAP_W-1:0] tap;
    logic [CNT_W-1:0] shifted;
    logic             act_led;
    logic             lit;

    assign mode    = ch_mode[2*i +: 2];
    assign tap     = ch_tap[TAP_W*i +: TAP_W];
    assign shifted = cnt_q >> sat_tap(32'(tap), CNT_W);

    led_act_fsm #(
      .STRETCH(STRETCH)
    ) u_act_fsm (
      .clk   (clk),
      .reset (reset),
      .enable(mode == LED_ACT),
      .evt   (ch_event[i]),
      .led   (act_led)
    );

    always_comb begin
      lit = 1'b0;
      unique case (mode)
        LED_OFF:   lit = 1'b0;
        LED_ON:    lit = 1'b1;
        LED_BLINK: lit = shifted[0];
        LED_ACT:   lit = act_led;
      endcase
    end

    assign led_d[i] = lit;
  end

endmodule

// File: tb/tb_led_activity_blinker.sv
// Bench for led_activity_blinker: directed scenarios plus random traffic against a phase model.
module tb_led_activity_blinker;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 8;
  localparam int STRETCH = 4;
  localparam int TAP_W   = 5;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [2*NUM_CH-1:0]     ch_mode;
  logic [TAP_W*NUM_CH-1:0] ch_tap;
  logic [NUM_CH-1:0]       ch_event;
  logic [NUM_CH-1:0]       led_out;
  logic                    presc_wrap;

  led_activity_blinker #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .STRETCH(STRETCH),
    .TAP_W  (TAP_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_mode   (ch_mode),
    .ch_tap    (ch_tap),
    .ch_event  (ch_event),
    .led_out   (led_out),
    .presc_wrap(presc_wrap)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          m_cnt;
  int          wraps_seen;
  int          lit_cnt;
  bit          m_act  [NUM_CH];
  bit          m_pend [NUM_CH];
  int          m_age  [NUM_CH];
  logic [NUM_CH-1:0] exp_led;
  logic        exp_wrap;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    m_cnt = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_act[i]  = 1'b0;
      m_pend[i] = 1'b0;
      m_age[i]  = 0;
    end
  endtask

  // Activity is modelled as a burst phase counter running mod 2*STRETCH: first half lit.
  task automatic tick();
    for (int i = 0; i < NUM_CH; i++) begin
      int md;
      int tp;
      md = int'(ch_mode[2*i +: 2]);
      tp = int'(ch_tap[TAP_W*i +: TAP_W]);
      if (tp > CNT_W - 1) tp = CNT_W - 1;
      case (md)
        0:       exp_led[i] = 1'b0;
        1:       exp_led[i] = 1'b1;
        2:       exp_led[i] = ((m_cnt >> tp) % 2) == 1;
        default: exp_led[i] = m_act[i] && (m_age[i] < STRETCH);
      endcase
      if (md != 3) begin
        m_act[i] = 1'b0; m_pend[i] = 1'b0; m_age[i] = 0;
      end else if (!m_act[i]) begin
        if (ch_event[i]) begin m_act[i] = 1'b1; m_age[i] = 0; end
      end else if (m_age[i] == 2*STRETCH - 1) begin
        if (m_pend[i] || ch_event[i]) begin m_age[i] = 0; m_pend[i] = 1'b0; end
        else m_act[i] = 1'b0;
      end else begin
        m_age[i]++;
        if (ch_event[i]) m_pend[i] = 1'b1;
      end
    end
    exp_wrap = (m_cnt == (1 << CNT_W) - 1);
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++)
      check_bit($sformatf("led_ch%0d@%0t", i, $time), led_out[i], exp_led[i]);
    check_bit($sformatf("wrap@%0t", $time), presc_wrap, exp_wrap);
    if (presc_wrap) wraps_seen++;
    if (led_out[0]) lit_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    ch_mode  = '0;
    ch_tap   = '0;
    ch_event = '0;
    #1;
    check_int("reset_led", int'(led_out), 0);
    check_bit("reset_wrap", presc_wrap, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    reset_model();

    // Prescaler wrap with every channel OFF.
    wraps_seen = 0;
    repeat (256) tick();
    check_int("wrap_count", wraps_seen, 1);
    check_bit("wrap_at_256", presc_wrap, 1'b1);

    // BLINK taps 0, 3, saturating 31, plus ON.
    ch_tap  = {5'd0, 5'd31, 5'd3, 5'd0};
    ch_mode = {2'd1, 2'd2, 2'd2, 2'd2};
    repeat (300) tick();

    // Single activity event on ch0.
    ch_mode = 8'b0000_0011;
    repeat (2) tick();
    lit_cnt = 0;
    ch_event = 4'b0001;
    tick();
    ch_event = '0;
    repeat (14) tick();
    check_int("single_lit_count", lit_cnt, STRETCH);

    // Continuous traffic then release.
    ch_event = 4'b0001;
    repeat (40) tick();
    ch_event = '0;
    repeat (24) tick();

    // Mode change mid-FLASH.
    ch_event = 4'b0001;
    tick();
    ch_event = '0;
    repeat (2) tick();
    ch_mode = 8'b0000_0000;
    tick();
    check_bit("off_mid_flash", led_out[0], 1'b0);
    ch_mode = 8'b0000_0011;
    lit_cnt = 0;
    repeat (12) tick();
    check_int("no_relight", lit_cnt, 0);

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        int c;
        c = $urandom_range(0, NUM_CH - 1);
        ch_mode[2*c +: 2] = 2'($urandom_range(0, 3));
        ch_tap[TAP_W*c +: TAP_W] = 5'($urandom_range(0, 31));
      end
      for (int c = 0; c < NUM_CH; c++) ch_event[c] = ($urandom_range(0, 3) == 0);
      tick();
    end

    // Async reset mid-FLASH on all channels.
    ch_mode  = 8'hFF;
    ch_event = 4'hF;
    tick();
    ch_event = 4'hF;
    tick();
    ch_event = '0;
    tick();
    check_int("all_flashing", int'(led_out), 15);
    #3;
    reset = 1'b1;
    #1;
    check_int("async_reset_led", int'(led_out), 0);
    check_bit("async_reset_wrap", presc_wrap, 1'b0);
    #2;
    reset = 1'b0;
    reset_model();
    lit_cnt = 0;
    repeat (20) tick();
    check_int("no_replay", lit_cnt, 0);
    ch_tap  = {5'd3, 5'd2, 5'd1, 5'd0};
    ch_mode = 8'hAA;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
